ipbb_prio_rr_lock_arb: RTL and testbench

IPBB_PRIO_RR_LOCK_ARB -- requirements
Module: ipbb_prio_rr_lock_arb

---
 rtl/ipbb_prio_arb_pkg.sv | 19 +
 rtl/ipbb_rr_pick.sv | 32 +++
 rtl/ipbb_prio_rr_lock_arb.sv | 172 +++++++++++++++++
 tb/tb_ipbb_prio_rr_lock_arb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ipbb_prio_arb_pkg.sv
// Shared types and width helpers for the priority round-robin lock arbiter.
package ipbb_prio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_e;

    // max(1, clog2(n)) so a single-entry dimension still gets a 1-bit field
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int limit);
        return idx_width(limit + 1);
    endfunction

endpackage

// File: rtl/ipbb_rr_pick.sv
// Combinational masked round-robin finder: first set bit at or above ptr, else first set bit overall.
module ipbb_rr_pick
    import ipbb_prio_arb_pkg::*;
#(
    parameter int NUM_QUE = 4,
    localparam int QW = idx_width(NUM_QUE)
) (
    input  logic [NUM_QUE-1:0] req,
    input  logic [QW-1:0]      ptr,
    output logic [QW-1:0]      id,
    output logic               vld
);

    logic [NUM_QUE-1:0] masked;

    always_comb begin
        masked = '0;
        id     = '0;
        vld    = |req;
        for (int i = 0; i < NUM_QUE; i++) begin
            masked[i] = req[i] && (QW'(i) >= ptr);
        end
        // Descending scans: the last hit written is the lowest index.
        for (int i = NUM_QUE - 1; i >= 0; i--) begin
            if (req[i]) id = QW'(i);
        end
        for (int i = NUM_QUE - 1; i >= 0; i--) begin
            if (masked[i]) id = QW'(i);
        end
    end

endmodule

// File: rtl/ipbb_prio_rr_lock_arb.sv
// Strict-priority arbiter with per-priority round-robin, starvation promotion
// and a lock mode that pins the grant to one queue across multi-beat transfers.
module ipbb_prio_rr_lock_arb
    import ipbb_prio_arb_pkg::*;
#(
    parameter int NUM_QUE      = 4,
    parameter int NUM_PRIORITY = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int QW = idx_width(NUM_QUE),
    localparam int PW = idx_width(NUM_PRIORITY),
    localparam int CW = cnt_width(STARVE_LIMIT)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PRIORITY-1:0][NUM_QUE-1:0]  req,
    input  logic                                  en,
    input  logic                                  gnt_ack,
    input  logic                                  ack_eop,
    output logic                                  gnt_vld,
    output logic [QW-1:0]                         gnt_id,
    output logic [PW-1:0]                         gnt_prio_id,
    output logic                                  gnt_starved,
    output logic                                  locked
);

    // Handshake: a grant is offered while gnt_vld=1; the consumer accepts it
    // with a one-cycle gnt_ack (ack_eop=1 releases, 0 locks). gnt_ack while
    // gnt_vld=0 or in IDLE has no effect.

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_e state, state_nxt;

    logic                    gnt_vld_nxt, gnt_starved_nxt, locked_nxt;
    logic [QW-1:0]           gnt_id_nxt;
    logic [PW-1:0]           gnt_prio_id_nxt;
    logic [QW-1:0]           ptr     [NUM_PRIORITY];
    logic [QW-1:0]           ptr_nxt [NUM_PRIORITY];
    logic [CW-1:0]           cnt     [NUM_PRIORITY];
    logic [CW-1:0]           cnt_nxt [NUM_PRIORITY];
    logic [QW-1:0]           pick_id [NUM_PRIORITY];
    logic [NUM_PRIORITY-1:0] pick_vld, starving;
    logic                    ack_ok, rel_ev, lock_ev, arb;
    logic                    win_vld, win_starved;
    logic [PW-1:0]           win_prio;
    logic [QW-1:0]           win_id;
    logic [QW-1:0]           ptr_inc;

    assign ack_ok  = gnt_ack && gnt_vld && (state != ST_IDLE);
    assign rel_ev  = ack_ok && ack_eop;
    assign lock_ev = ack_ok && !ack_eop && (state == ST_GNT);
    assign ptr_inc = (gnt_id == QW'(NUM_QUE - 1)) ? '0 : gnt_id + QW'(1);

    // Pointers and counters are advanced first so a release re-arbitrates on updated state.
    always_comb begin
        for (int p = 0; p < NUM_PRIORITY; p++) begin
            ptr_nxt[p] = ptr[p];
            cnt_nxt[p] = cnt[p];
            if (rel_ev && gnt_prio_id == PW'(p)) ptr_nxt[p] = ptr_inc;
            if (p == 0 || !(|req[p]) || (rel_ev && gnt_prio_id == PW'(p))) begin
                cnt_nxt[p] = '0;
            end else if (rel_ev && gnt_prio_id < PW'(p) && cnt[p] != LIMIT) begin
                cnt_nxt[p] = cnt[p] + CW'(1);
            end
            starving[p] = (STARVE_LIMIT != 0) && (p != 0) && (cnt_nxt[p] == LIMIT);
        end
    end

    for (genvar p = 0; p < NUM_PRIORITY; p++) begin : g_pick
        ipbb_rr_pick #(.NUM_QUE(NUM_QUE)) u_pick (
            .req (req[p]),
            .ptr (ptr_nxt[p]),
            .id  (pick_id[p]),
            .vld (pick_vld[p])
        );
    end

    always_comb begin
        win_vld     = |pick_vld;
        win_prio    = '0;
        win_id      = '0;
        win_starved = 1'b0;
        for (int p = NUM_PRIORITY - 1; p >= 0; p--) begin
            if (pick_vld[p]) begin
                win_prio = PW'(p);
                win_id   = pick_id[p];
            end
        end
        // A starving priority overrides the plain priority order.
        for (int p = NUM_PRIORITY - 1; p >= 0; p--) begin
            if (pick_vld[p] && starving[p]) begin
                win_prio    = PW'(p);
                win_id      = pick_id[p];
                win_starved = 1'b1;
            end
        end
    end

    assign arb = en && win_vld;

    always_comb begin
        state_nxt       = state;
        gnt_vld_nxt     = gnt_vld;
        gnt_id_nxt      = gnt_id;
        gnt_prio_id_nxt = gnt_prio_id;
        gnt_starved_nxt = gnt_starved;
        locked_nxt      = locked;
        case (state)
            ST_IDLE: begin
                if (arb) begin
                    state_nxt       = ST_GNT;
                    gnt_vld_nxt     = 1'b1;
                    gnt_id_nxt      = win_id;
                    gnt_prio_id_nxt = win_prio;
                    gnt_starved_nxt = win_starved;
                    locked_nxt      = 1'b0;
                end
            end
            ST_GNT, ST_LOCK: begin
                if (rel_ev && arb) begin
                    state_nxt       = ST_GNT;
                    gnt_vld_nxt     = 1'b1;
                    gnt_id_nxt      = win_id;
                    gnt_prio_id_nxt = win_prio;
                    gnt_starved_nxt = win_starved;
                    locked_nxt      = 1'b0;
                end else if (rel_ev) begin
                    state_nxt       = ST_IDLE;
                    gnt_vld_nxt     = 1'b0;
                    gnt_starved_nxt = 1'b0;
                    locked_nxt      = 1'b0;
                end else if (lock_ev || state == ST_LOCK) begin
                    state_nxt   = ST_LOCK;
                    locked_nxt  = 1'b1;
                    gnt_vld_nxt = req[gnt_prio_id][gnt_id];
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                gnt_vld_nxt = 1'b0;
                locked_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            gnt_vld     <= 1'b0;
            gnt_id      <= '0;
            gnt_prio_id <= '0;
            gnt_starved <= 1'b0;
            locked      <= 1'b0;
            for (int p = 0; p < NUM_PRIORITY; p++) begin
                ptr[p] <= '0;
                cnt[p] <= '0;
            end
        end else begin
            state       <= state_nxt;
            gnt_vld     <= gnt_vld_nxt;
            gnt_id      <= gnt_id_nxt;
            gnt_prio_id <= gnt_prio_id_nxt;
            gnt_starved <= gnt_starved_nxt;
            locked      <= locked_nxt;
            for (int p = 0; p < NUM_PRIORITY; p++) begin
                ptr[p] <= ptr_nxt[p];
                cnt[p] <= cnt_nxt[p];
            end
        end
    end

endmodule

// File: tb/tb_ipbb_prio_rr_lock_arb.sv
// Directed bench for ipbb_prio_rr_lock_arb (4 queues, 4 priorities, starve limit 4).
module tb_ipbb_prio_rr_lock_arb;

    logic             clk;
    logic             rst_n;
    logic [3:0][3:0]  req;
    logic             en;
    logic             gnt_ack;
    logic             ack_eop;
    logic             gnt_vld;
    logic [1:0]       gnt_id;
    logic [1:0]       gnt_prio_id;
    logic             gnt_starved;
    logic             locked;

    int n_checks = 0;
    int n_errors = 0;

    ipbb_prio_rr_lock_arb #(
        .NUM_QUE      (4),
        .NUM_PRIORITY (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .en          (en),
        .gnt_ack     (gnt_ack),
        .ack_eop     (ack_eop),
        .gnt_vld     (gnt_vld),
        .gnt_id      (gnt_id),
        .gnt_prio_id (gnt_prio_id),
        .gnt_starved (gnt_starved),
        .locked      (locked)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input logic vld, input logic [1:0] prio,
                                input logic [1:0] id);
        check_eq({tag, ".vld"}, 32'(gnt_vld), 32'(vld));
        check_eq({tag, ".prio"}, 32'(gnt_prio_id), 32'(prio));
        check_eq({tag, ".id"}, 32'(gnt_id), 32'(id));
    endtask

    // driver tasks
    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        gnt_ack = 1'b0;
        ack_eop = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_ack(input logic eop);
        gnt_ack = 1'b1;
        ack_eop = eop;
        tick();
        gnt_ack = 1'b0;
        ack_eop = 1'b0;
    endtask

    logic [1:0] rr_exp [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        en      = 1'b0;
        gnt_ack = 1'b0;
        ack_eop = 1'b0;
        tick();
        tick();
        check_eq("rst.vld", 32'(gnt_vld), 0);
        check_eq("rst.locked", 32'(locked), 0);
        check_eq("rst.id", 32'(gnt_id), 0);
        check_eq("rst.prio", 32'(gnt_prio_id), 0);
        check_eq("rst.starved", 32'(gnt_starved), 0);

        // round robin, back-to-back grants
        rst_n  = 1'b1;
        en     = 1'b1;
        req[0] = 4'b1010;
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_grant($sformatf("rr%0d", i), 1'b1, 2'd0, rr_exp[i]);
            pulse_ack(1'b1);
        end
        req = '0;
        pulse_ack(1'b1);
        check_eq("rr.idle_vld", 32'(gnt_vld), 0);

        // strict priority
        do_reset();
        req[0][2] = 1'b1;
        req[2][0] = 1'b1;
        tick();
        expect_grant("prio.first", 1'b1, 2'd0, 2'd2);
        req[0][2] = 1'b0;
        pulse_ack(1'b1);
        expect_grant("prio.second", 1'b1, 2'd2, 2'd0);
        check_eq("prio.second_starved", 32'(gnt_starved), 0);
        req = '0;
        pulse_ack(1'b1);

        // starvation promotion after four higher-priority releases
        do_reset();
        req[0] = 4'b1111;
        req[1] = 4'b1000;
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_grant($sformatf("starve.p0_%0d", i), 1'b1, 2'd0, 2'(i));
            check_eq($sformatf("starve.p0_%0d_flag", i), 32'(gnt_starved), 0);
            pulse_ack(1'b1);
        end
        expect_grant("starve.promoted", 1'b1, 2'd1, 2'd3);
        check_eq("starve.promoted_flag", 32'(gnt_starved), 1);
        pulse_ack(1'b1);
        expect_grant("starve.resume", 1'b1, 2'd0, 2'd0);
        check_eq("starve.resume_flag", 32'(gnt_starved), 0);
        req = '0;
        pulse_ack(1'b1);

        // lock mode
        do_reset();
        req[0] = 4'b0010;
        tick();
        expect_grant("lock.grant", 1'b1, 2'd0, 2'd1);
        pulse_ack(1'b0);
        check_eq("lock.locked", 32'(locked), 1);
        expect_grant("lock.held", 1'b1, 2'd0, 2'd1);
        req[0] = 4'b0100;
        tick();
        check_eq("lock.drop_locked", 32'(locked), 1);
        expect_grant("lock.drop", 1'b0, 2'd0, 2'd1);
        pulse_ack(1'b1);
        check_eq("lock.ign_locked", 32'(locked), 1);
        expect_grant("lock.ign", 1'b0, 2'd0, 2'd1);
        req[0] = 4'b0110;
        tick();
        expect_grant("lock.reassert", 1'b1, 2'd0, 2'd1);
        check_eq("lock.reassert_locked", 32'(locked), 1);
        pulse_ack(1'b1);
        expect_grant("lock.after_rel", 1'b1, 2'd0, 2'd2);
        check_eq("lock.after_rel_locked", 32'(locked), 0);
        req = '0;
        pulse_ack(1'b1);
        check_eq("lock.idle_vld", 32'(gnt_vld), 0);

        // reset during lock
        do_reset();
        req[0] = 4'b0010;
        tick();
        pulse_ack(1'b0);
        check_eq("rlock.locked", 32'(locked), 1);
        rst_n  = 1'b0;
        req[0] = 4'b0011;
        tick();
        check_eq("rlock.vld", 32'(gnt_vld), 0);
        check_eq("rlock.locked_clr", 32'(locked), 0);
        rst_n = 1'b1;
        tick();
        expect_grant("rlock.next", 1'b1, 2'd0, 2'd0);
        req = '0;
        pulse_ack(1'b1);

        // enable gating
        en     = 1'b0;
        req[3] = 4'b0100;
        tick();
        pulse_ack(1'b1);
        check_eq("en.blocked", 32'(gnt_vld), 0);
        en = 1'b1;
        tick();
        expect_grant("en.grant", 1'b1, 2'd3, 2'd2);
        en = 1'b0;
        pulse_ack(1'b1);
        check_eq("en.rel_idle", 32'(gnt_vld), 0);
        en = 1'b1;
        tick();
        expect_grant("en.regrant", 1'b1, 2'd3, 2'd2);
        req = '0;
        pulse_ack(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
